// File: rtl/key_cmd_gen.sv
// rtl/key_cmd_gen.sv - held-key to game-command generator with typematic repeat and 4-entry FIFO
//
// Ports:
//   clk        system clock
//   rst        asynchronous reset, active-low
//   key        1 while any key is held
//   key_num    key code: 0=up 1=left 2=down 3=right 4=enter 5=other
//   cmd        FIFO head command code (registered)
//   cmd_valid  FIFO non-empty (registered)
//   cmd_ready  consumer accepts cmd this cycle
//   level      FIFO occupancy 0..4 (registered)
//   drop       one-cycle pulse after a push was discarded on a full FIFO

module key_cmd_gen #(
    parameter int DELAY_CYC  = 25_000_000,
    parameter int PERIOD_CYC = 10_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key,
    input  logic [2:0] key_num,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [2:0] level,
    output logic       drop
);

    localparam int MAX_CYC = (DELAY_CYC > PERIOD_CYC) ? DELAY_CYC : PERIOD_CYC;
    localparam int CW      = $clog2(MAX_CYC);

    localparam logic [CW-1:0] DLY_LAST = CW'(DELAY_CYC - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(PERIOD_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;
    localparam logic [2:0]    CODE_ENT = 3'd4;

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t        state_q, state_d;
    logic [2:0]    cur_q, cur_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          emit;
    logic [2:0]    emit_code;
    logic          key_ok;

    assign key_ok = key && (key_num <= CODE_ENT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        cnt_d     = cnt_q;
        emit      = 1'b0;
        emit_code = cur_q;
        if (!key_ok) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    emit      = 1'b1;
                    emit_code = key_num;
                    cur_d     = key_num;
                    cnt_d     = '0;
                    state_d   = HOLD;
                end
                HOLD: begin
                    if (key_num != cur_q) begin
                        emit      = 1'b1;
                        emit_code = key_num;
                        cur_d     = key_num;
                        cnt_d     = '0;
                    end else if (cur_q != CODE_ENT && cnt_q == DLY_LAST) begin
                        emit    = 1'b1;
                        cnt_d   = '0;
                        state_d = REPEAT;
                    end else if (cnt_q != CNT_MAX) begin
                        // Enter never repeats; its counter just parks at the top.
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                REPEAT: begin
                    if (key_num != cur_q) begin
                        emit      = 1'b1;
                        emit_code = key_num;
                        cur_d     = key_num;
                        cnt_d     = '0;
                        state_d   = HOLD;
                    end else if (cnt_q == PER_LAST) begin
                        emit  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    logic [2:0] mem_q [4];
    logic [2:0] mem_d [4];
    logic [1:0] wr_q, wr_d, rd_q, rd_d;
    logic [2:0] count_q, count_d;
    logic [2:0] cmd_q, cmd_d;
    logic       valid_q, valid_d;
    logic       drop_q, drop_d;
    logic       pop, push, full;

    assign full = (count_q == 3'd4);
    assign pop  = valid_q && cmd_ready;
    // A pop in the same cycle frees the slot, so a push on a full FIFO still lands.
    assign push = emit && (!full || pop);

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_q] = emit_code;
        end
        wr_d    = wr_q + 2'(push);
        rd_d    = rd_q + 2'(pop);
        count_d = count_q + 3'(push) - 3'(pop);
        // Head is precomputed so cmd comes straight from a flop.
        cmd_d   = mem_d[rd_d];
        valid_d = (count_d != 3'd0);
        drop_d  = emit && full && !pop;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
            cmd_q   <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
            cmd_q   <= cmd_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
        end
    end

    assign cmd       = cmd_q;
    assign cmd_valid = valid_q;
    assign level     = count_q;
    assign drop      = drop_q;

endmodule

// File: tb/tb_key_cmd_gen.sv
// tb/tb_key_cmd_gen.sv - self-checking bench for key_cmd_gen against a timing-rule reference model

module tb_key_cmd_gen;

    localparam int D = 8;
    localparam int P = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       key;
    logic [2:0] key_num;
    logic [2:0] cmd;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] level;
    logic       drop;

    key_cmd_gen #(.DELAY_CYC(D), .PERIOD_CYC(P)) dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .key_num   (key_num),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .level     (level),
        .drop      (drop)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    int mq[$];
    int held;
    int start;
    int cyc;
    int m_drop;
    int popped[$];
    int ndrop;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        held   = -1;
        start  = 0;
        cyc    = 0;
        m_drop = 0;
    endtask

    // Emission rule: a new valid code emits at once; the same code re-emits
    // at age D, D+P, D+2P, ... unless it is enter.
    task automatic model_edge(input int k, input int kn, input int rdy);
        int emit, code, age, pop;
        emit = 0;
        code = 0;
        pop  = (mq.size() > 0 && rdy != 0) ? 1 : 0;
        if (k != 0 && kn <= 4) begin
            if (held < 0 || kn != held) begin
                emit  = 1;
                code  = kn;
                held  = kn;
                start = cyc;
            end else begin
                age = cyc - start;
                if (held != 4 && age >= D && ((age - D) % P) == 0) begin
                    emit = 1;
                    code = held;
                end
            end
        end else begin
            held = -1;
        end
        if (pop != 0) void'(mq.pop_front());
        m_drop = 0;
        if (emit != 0) begin
            if (mq.size() < 4) mq.push_back(code);
            else m_drop = 1;
        end
        cyc++;
    endtask

    task automatic step(input int k, input int kn, input int rdy);
        key       = k[0];
        key_num   = kn[2:0];
        cmd_ready = rdy[0];
        if (cmd_valid && cmd_ready) popped.push_back(int'(cmd));
        @(posedge clk);
        model_edge(k, kn, rdy);
        #1;
        if (drop) ndrop++;
        chk("level", int'(level), mq.size());
        chk("valid", int'(cmd_valid), (mq.size() != 0) ? 1 : 0);
        if (mq.size() > 0) chk("cmd", int'(cmd), mq[0]);
        chk("drop", int'(drop), m_drop);
    endtask

    task automatic run(input int k, input int kn, input int rdy, input int n);
        for (int i = 0; i < n; i++) step(k, kn, rdy);
    endtask

    initial begin
        int codes[6];
        int k, kn, rdy;
        codes = '{0, 1, 2, 3, 0, 1};
        key = 1'b0;
        key_num = 3'd0;
        cmd_ready = 1'b0;

        #2 rst = 1'b0;
        #1;
        chk("rst_valid", int'(cmd_valid), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_cmd", int'(cmd), 0);
        chk("rst_drop", int'(drop), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        model_reset();

        // single short press
        popped.delete(); ndrop = 0;
        run(1, 1, 1, 3);
        run(0, 0, 1, 3);
        chk("t1_npop", popped.size(), 1);
        if (popped.size() > 0) chk("t1_val", popped[0], 1);
        chk("t1_drops", ndrop, 0);

        // held up key: pushes at 0, 8, 12, 16
        popped.delete(); ndrop = 0;
        run(1, 0, 1, 20);
        run(0, 0, 1, 3);
        chk("t2_npop", popped.size(), 4);
        foreach (popped[i]) chk("t2_val", popped[i], 0);
        chk("t2_drops", ndrop, 0);

        // enter never repeats
        popped.delete();
        run(1, 4, 1, 30);
        run(0, 0, 1, 3);
        chk("t3_npop", popped.size(), 1);
        if (popped.size() > 0) chk("t3_val", popped[0], 4);

        // overflow with consumer stalled
        ndrop = 0;
        foreach (codes[i]) begin
            run(1, codes[i], 0, 1);
            run(0, 0, 0, 1);
        end
        chk("t4_level", int'(level), 4);
        chk("t4_drops", ndrop, 2);
        popped.delete();
        run(0, 0, 1, 6);
        chk("t4_npop", popped.size(), 4);
        foreach (popped[i]) chk("t4_order", popped[i], i);
        chk("t4_empty", int'(level), 0);

        // key change mid-hold restarts the delay
        popped.delete();
        run(1, 0, 1, 5);
        run(1, 3, 1, 9);
        run(0, 0, 1, 3);
        chk("t5_npop", popped.size(), 3);
        if (popped.size() == 3) begin
            chk("t5_v0", popped[0], 0);
            chk("t5_v1", popped[1], 3);
            chk("t5_v2", popped[2], 3);
        end

        // asynchronous reset in REPEAT with two entries queued
        run(1, 0, 0, 11);
        chk("t6_pre_level", int'(level), 2);
        #1 rst = 1'b0;
        #1;
        chk("t6_async_valid", int'(cmd_valid), 0);
        chk("t6_async_level", int'(level), 0);
        model_reset();
        key = 1'b1;
        key_num = 3'd2;
        #1 rst = 1'b1;
        run(1, 2, 0, 1);
        chk("t6_first_cmd", int'(cmd), 2);
        chk("t6_first_level", int'(level), 1);
        run(0, 0, 1, 2);

        // randomized hold/switch/release traffic
        k = 0; kn = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) k = 1 - k;
            if ($urandom_range(0, 7) == 0) kn = $urandom_range(0, 5);
            rdy = ($urandom_range(0, 2) != 0) ? 1 : 0;
            step(k, kn, rdy);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/key_cmd_gen.md
# key_cmd_gen

Converts the keyboard block's held-key level (`key`) and decoded key code (`key_num`) into discrete game commands with typematic auto-repeat, and queues them in a 4-entry FIFO with a valid/ready handshake. It sits directly downstream of the keyboard block and upstream of the game control FSM, which pops one command per move. ENTER never auto-repeats. Unknown keys (code 5) produce no command.

## Interface
- `DELAY_CYC`, default 25_000_000: cycles a key must be held before the first repeat (250 ms at 100 MHz); must be ≥ 2.
- `PERIOD_CYC`, default 10_000_000: cycles between subsequent repeats; must be ≥ 2.
- `clk`  in  1  system clock; one clock; reset is asynchronous and active-low.
- `rst`  in  1  asynchronous reset, active-low (`rst`=0 resets).
- `key`  in  1  level, 1 while any key is held; synchronous to `clk`.
- `key_num`  in  3  code: 0=up, 1=left, 2=down, 3=right, 4=enter, 5=other.
- `cmd`  out  3  FIFO head command code (0–4).
- `cmd_valid`  out  1  FIFO non-empty.
- `cmd_ready`  in  1  consumer accepts `cmd` this cycle.
- `level`  out  3  FIFO occupancy, 0–4.
- `drop`  out  1  one-cycle pulse when a command is discarded because the FIFO is full.

## Operation
- Counter `cnt` width: $clog2(max(DELAY_CYC, PERIOD_CYC)). `cur` is a 3-bit latched key code.
- The FSM has 3 states: IDLE, HOLD and REPEAT.
  - In any state, if `key`=0 or `key_num`=5 and the state is not IDLE, the FSM goes to IDLE and emits nothing.
  - **IDLE:** if `key`=1 and `key_num`≤4, it emits `key_num`, sets `cur`←`key_num`, sets `cnt`←0 and goes to HOLD. Entry is level-sensitive: a key still held when the FSM returns to IDLE emits again.
  - **HOLD:**
    - If `key_num`≠`cur` (valid code), it emits the new code, sets `cur`←`key_num`, sets `cnt`←0 and stays in HOLD.
    - Else if `cur`≠4 and `cnt`=DELAY_CYC−1, it emits `cur`, sets `cnt`←0 and goes to REPEAT.
    - Else `cnt`←`cnt`+1. With `cur`=4, `cnt` saturates and the FSM stays in HOLD.
  - **REPEAT:**
    - If `key_num`≠`cur`, it emits the new code, sets `cur`/`cnt` as in HOLD and goes to HOLD.
    - Else if `cnt`=PERIOD_CYC−1, it emits `cur` and sets `cnt`←0.
    - Else `cnt`+1.
- Emit means push one entry into the FIFO. There is at most one push per cycle.
- FIFO: 4 entries, circular, with 2-bit write/read pointers and a 3-bit count.
  - Pop occurs when `cmd_valid` && `cmd_ready`.
  - **Push when full:**
    - Without a same-cycle pop, the entry is discarded and `drop`=1 for one cycle.
    - With a same-cycle pop, the push succeeds and `level` stays 4.
  - A pop when empty is ignored.
  - A simultaneous push and pop when non-full leaves `level` unchanged.
- Commands leave the FIFO in push order.
- Inputs are assumed already synchronous to `clk`; no synchronizer is used.

## Timing
- **Reset (asynchronous, while `rst`=0):**
  - state = IDLE, `cnt`=0, `cur`=0.
  - FIFO is empty; `cmd_valid`=0, `cmd`=0, `level`=0, `drop`=0.
  - These values take effect immediately, without waiting for a clock edge.
- **Reset mid-operation:** queued commands are lost. After `rst` returns to 1, a still-held valid key emits on the first edge.
- **Latency:**
  - A key sampled at edge N is written at edge N.
  - `cmd_valid`/`cmd`/`level` reflect it after edge N; all outputs are registered.
- **Repeat schedule,** where the first emit is at edge E:
  - Repeats occur at E+DELAY_CYC, then every PERIOD_CYC edges.
  - Repeats continue while the same key is held.
- **`cmd` handshake:** `cmd` is stable while `cmd_valid`=1 and `cmd_ready`=0. On a pop at edge P, the next head appears after P.
- `drop` is asserted only in the cycle following the rejected push edge.

## Test plan
Benches use DELAY_CYC=8 and PERIOD_CYC=4.
1. `cmd_ready`=1; `key`=1 with `key_num`=1 for 3 cycles, then release → exactly one `cmd`=1 handshake; `drop` never asserts.
2. `cmd_ready`=1; `key_num`=0 held from edge 0 through edge 19, released at edge 20 → four `cmd`=0 pushes, at edges 0, 8, 12 and 16.
3. `key_num`=4 held for 30 cycles → exactly one `cmd`=4; no repeat.
4. `cmd_ready`=0; six distinct press/release pairs with codes 0,1,2,3,0,1 → `level`=4 and `drop` pulses twice. Then `cmd_ready`=1 → pops 0,1,2,3 in order, and `level` reaches 0.
5. Hold `key_num`=0 for 5 cycles, then switch to 3 while `key`=1 → immediate `cmd`=3 push. The next repeat of 3 occurs 8 edges later, with no repeat of 0.
6. During REPEAT with 2 entries queued, drive `rst`=0 between clock edges → `cmd_valid`=0 and `level`=0 with no clock edge. Release `rst` with `key`=1, `key_num`=2 → `cmd`=2 pushed on the first edge.
